// File: rtl/instruction_line_memory.sv
// Instruction line store: answers 64-bit line-fill requests after LATENCY cycles, with a halfword write port.
// Optional even parity on the returned line is enabled by defining ILM_PARITY_EN.
module instruction_line_memory #(
    parameter int LATENCY     = 5,
    parameter int DEPTH_LINES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    input  logic        req_flush,
    output logic        resp_valid,
    output logic [15:0] resp_addr,
    output logic [63:0] dataLine,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
`ifdef ILM_PARITY_EN
    output logic        resp_parity,
`endif
    output logic [1:0]  state_dbg
);

    localparam int IDX_W = $clog2(DEPTH_LINES);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready && !req_flush;
    // the requester holds req_valid/req_addr until then, and nothing is queued while busy.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] addr_q;
    logic        accept;
    logic [63:0] rd_line;
    logic [15:0] mem [DEPTH_LINES][4];
    logic        unused_bits;

    assign accept    = req_valid && req_ready && !req_flush;
    assign rd_line   = {mem[addr_q[3 +: IDX_W]][0], mem[addr_q[3 +: IDX_W]][1],
                        mem[addr_q[3 +: IDX_W]][2], mem[addr_q[3 +: IDX_W]][3]};
    assign state_dbg = state;
    assign unused_bits = ^{req_addr[15:3+IDX_W], req_addr[2:0], wr_addr[15:3+IDX_W], wr_addr[0]};

    // Lane 0 of each line is the halfword at offset 0 and lands in dataLine[63:48].
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[3 +: IDX_W]][wr_addr[2:1]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            addr_q     <= 16'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_addr  <= 16'd0;
            dataLine   <= 64'd0;
`ifdef ILM_PARITY_EN
            resp_parity <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_BUSY: begin
                    if (req_flush) begin
                        state     <= S_IDLE;
                        cnt       <= 4'd0;
                        req_ready <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        // Read happens on this edge, so a same-edge write is not seen.
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_addr  <= addr_q;
                        dataLine   <= rd_line;
`ifdef ILM_PARITY_EN
                        resp_parity <= ^rd_line;
`endif
                        req_ready  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    // RESP always falls back to IDLE, so it takes the next request on its
                    // closing edge, giving one request per LATENCY+1 cycles.
                    if (accept) begin
                        state     <= S_BUSY;
                        cnt       <= 4'(LATENCY - 1);
                        addr_q    <= {req_addr[15:3], 3'b000};
                        req_ready <= 1'b0;
                    end else begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
